// File: rtl/regfile_bus_sched.sv
// regfile_bus_sched: round-robin scheduler expanding two requesters' register ops into register-file command sequences
module regfile_bus_sched #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][1:0]       req_op,
    input  logic [1:0][2:0]       req_sel_a,
    input  logic [1:0][2:0]       req_sel_b,
    input  logic [1:0][2:0]       req_sel_c,
    input  logic [1:0][WIDTH-1:0] req_wdata,
    output logic [3:0]            com,
    output logic [WIDTH-1:0]      bus_out,
    input  logic [WIDTH-1:0]      bus_in,
    output logic [1:0]            rsp_valid,
    output logic [WIDTH-1:0]      rsp_a,
    output logic [WIDTH-1:0]      rsp_b,
    output logic                  busy
);
    typedef enum logic [2:0] {IDLE, SEL, RDA, RDB, WRC, ALUWE, RDF, RSP} state_t;
    localparam logic [3:0] COM_NOP      = 4'd0;
    localparam logic [3:0] COM_READA    = 4'd1;
    localparam logic [3:0] COM_READB    = 4'd2;
    localparam logic [3:0] COM_LATCHC   = 4'd3;
    localparam logic [3:0] COM_LATCHSEL = 4'd4;
    localparam logic [3:0] COM_READF    = 4'd5;
    localparam logic [3:0] COM_ALU_WE   = 4'd6;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_ALU   = 2'd2;
    localparam logic [1:0] OP_FLAGS = 2'd3;

    state_t           state;
    logic             last, owner, g;
    logic [1:0]       op;
    logic [2:0]       sa, sb, sc;
    logic [WIDTH-1:0] wd;

    // g is the port granted this cycle: port 1 wins if alone, or if both are valid and port 0 went last
    assign g         = req_valid[1] & (~req_valid[0] | ~last);
    assign req_ready = (state == IDLE && !rst) ? {g, req_valid[0] & ~g} : 2'b00;
    assign busy      = state != IDLE;
    assign rsp_valid = state == RSP ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign bus_out   = state == SEL ? WIDTH'({sc, sb, sa}) : state == WRC ? wd : '0;

    always_comb begin
        com = state == SEL   ? COM_LATCHSEL :
              state == RDA   ? COM_READA    :
              state == RDB   ? COM_READB    :
              state == WRC   ? COM_LATCHC   :
              state == ALUWE ? COM_ALU_WE   :
              state == RDF   ? COM_READF    : COM_NOP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            owner <= 1'b0;
            op    <= '0;
            sa    <= '0;
            sb    <= '0;
            sc    <= '0;
            wd    <= '0;
            rsp_a <= '0;
            rsp_b <= '0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    owner <= g;
                    last  <= g;
                    op    <= req_op[g];
                    sa    <= req_sel_a[g];
                    sb    <= req_sel_b[g];
                    sc    <= req_sel_c[g];
                    wd    <= req_wdata[g];
                    state <= req_op[g] == OP_FLAGS ? RDF :
                             (req_op[g] == OP_WRITE && req_sel_c[g] == 3'd0) ? RSP : SEL;
                end
                SEL: state <= op == OP_WRITE ? WRC : RDA;
                RDA: begin
                    rsp_a <= bus_in;
                    state <= RDB;
                end
                RDB: begin
                    rsp_b <= bus_in;
                    state <= op == OP_ALU ? ALUWE : RSP;
                end
                RDF: begin
                    rsp_a <= bus_in;
                    state <= RSP;
                end
                WRC, ALUWE: state <= RSP;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_bus_sched.sv
// tb_regfile_bus_sched: directed-vector bench with a register-file read model driving bus_in from com
module tb_regfile_bus_sched;
    localparam int WIDTH = 16;
    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            req_valid, req_ready, rsp_valid;
    logic [1:0][1:0]       req_op;
    logic [1:0][2:0]       req_sel_a, req_sel_b, req_sel_c;
    logic [1:0][WIDTH-1:0] req_wdata;
    logic [3:0]            com;
    logic [WIDTH-1:0]      bus_out, bus_in, rsp_a, rsp_b;
    logic                  busy;
    logic [WIDTH-1:0]      ra = 16'h1111, rb = 16'h2222, rf = 16'h0000;
    int checks = 0, failures = 0;

    regfile_bus_sched #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_sel_a(req_sel_a), .req_sel_b(req_sel_b), .req_sel_c(req_sel_c),
        .req_wdata(req_wdata), .com(com), .bus_out(bus_out), .bus_in(bus_in),
        .rsp_valid(rsp_valid), .rsp_a(rsp_a), .rsp_b(rsp_b), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb bus_in = com == 4'd1 ? ra : com == 4'd2 ? rb : com == 4'd5 ? rf : 16'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] c, input logic [WIDTH-1:0] wd);
        req_valid[p] = 1'b1;
        req_op[p]    = op;
        req_sel_a[p] = a;
        req_sel_b[p] = b;
        req_sel_c[p] = c;
        req_wdata[p] = wd;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_op = '0;
        req_sel_a = '0;
        req_sel_b = '0;
        req_sel_c = '0;
        req_wdata = '0;
        step();
        set_req(0, 2'd0, 3'd1, 3'd2, 3'd0, 16'h0);
        #1;
        chk("ready_in_reset", req_ready, 2'b00);
        step();
        chk("rst_com", com, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_a", rsp_a, 0);
        chk("rst_bus_out", bus_out, 0);

        // READ2 on port 0
        rst = 1'b0;
        #1;
        chk("rd2_ready", req_ready, 2'b01);
        step();
        req_valid = '0;
        chk("rd2_t1_com", com, 4);
        chk("rd2_t1_bus", bus_out, 16'h0011);
        chk("rd2_t1_ready", req_ready, 0);
        step();
        chk("rd2_t2_com", com, 1);
        step();
        chk("rd2_t3_com", com, 2);
        step();
        chk("rd2_t4_rsp", rsp_valid, 2'b01);
        chk("rd2_t4_com", com, 0);
        chk("rd2_rsp_a", rsp_a, 16'h1111);
        chk("rd2_rsp_b", rsp_b, 16'h2222);
        step();
        chk("rd2_idle_rsp", rsp_valid, 0);
        chk("rd2_idle_busy", busy, 0);

        // WRITE on port 1
        set_req(1, 2'd1, 3'd0, 3'd0, 3'd5, 16'hBEEF);
        #1;
        chk("wr_ready", req_ready, 2'b10);
        step();
        req_valid = '0;
        chk("wr_t1_com", com, 4);
        chk("wr_t1_bus", bus_out, 16'h0140);
        step();
        chk("wr_t2_com", com, 3);
        chk("wr_t2_bus", bus_out, 16'hBEEF);
        step();
        chk("wr_t3_rsp", rsp_valid, 2'b10);
        chk("wr_keeps_rsp_a", rsp_a, 16'h1111);
        step();

        // WRITE to R_ZERO
        set_req(1, 2'd1, 3'd0, 3'd0, 3'd0, 16'h1234);
        #1;
        chk("wr0_ready", req_ready, 2'b10);
        step();
        req_valid = '0;
        chk("wr0_t1_rsp", rsp_valid, 2'b10);
        chk("wr0_t1_com", com, 0);
        step();
        chk("wr0_idle", busy, 0);

        // Both ports hold FLAGS from reset: grants alternate, one RDF per grant
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 2'd3, 3'd0, 3'd0, 3'd0, 16'h0);
        set_req(1, 2'd3, 3'd0, 3'd0, 3'd0, 16'h0);
        for (int i = 0; i < 12; i++) begin
            int k, p;
            k = i % 3;
            p = (i / 3) % 2;
            #1;
            chk($sformatf("rr_ready_%0d", i), req_ready, k == 0 ? (p ? 2 : 1) : 0);
            chk($sformatf("rr_com_%0d", i), com, k == 1 ? 5 : 0);
            chk($sformatf("rr_rsp_%0d", i), rsp_valid, k == 2 ? (p ? 2 : 1) : 0);
            step();
        end

        // ALU on port 0 while port 1 waits with READ2
        set_req(0, 2'd2, 3'd3, 3'd4, 3'd6, 16'h0);
        set_req(1, 2'd0, 3'd1, 3'd2, 3'd0, 16'h0);
        #1;
        chk("alu_ready", req_ready, 2'b01);
        step();
        req_valid[0] = 1'b0;
        chk("alu_t1_com", com, 4);
        chk("alu_t1_bus", bus_out, 16'h01A3);
        chk("alu_t1_ready", req_ready, 0);
        step();
        chk("alu_t2_com", com, 1);
        chk("alu_t2_ready", req_ready, 0);
        step();
        chk("alu_t3_com", com, 2);
        chk("alu_t3_ready", req_ready, 0);
        step();
        chk("alu_t4_com", com, 6);
        chk("alu_t4_ready", req_ready, 0);
        step();
        chk("alu_t5_rsp", rsp_valid, 2'b01);
        chk("alu_t5_ready", req_ready, 0);
        step();
        chk("p1_ready_after", req_ready, 2'b10);

        // port 1 READ2, reset during its RDA cycle
        step();
        req_valid = '0;
        chk("abort_sel", com, 4);
        step();
        chk("abort_rda", com, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_com", com, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rsp_a", rsp_a, 0);
        chk("abort_rsp_b", rsp_b, 0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("abort_no_rsp_%0d", i), rsp_valid, 0);
            step();
        end

        // READ2 to load rsp_b, then FLAGS must only touch rsp_a
        ra = 16'h3333;
        rb = 16'h4444;
        set_req(0, 2'd0, 3'd1, 3'd2, 3'd0, 16'h0);
        step();
        req_valid = '0;
        step();
        step();
        step();
        chk("pre_rsp", rsp_valid, 2'b01);
        chk("pre_rsp_b", rsp_b, 16'h4444);
        step();
        rf = 16'h00A5;
        set_req(1, 2'd3, 3'd0, 3'd0, 3'd0, 16'h0);
        #1;
        chk("fl_ready", req_ready, 2'b10);
        step();
        req_valid = '0;
        chk("fl_t1_com", com, 5);
        step();
        chk("fl_t2_rsp", rsp_valid, 2'b10);
        chk("fl_rsp_a", rsp_a, 16'h00A5);
        chk("fl_rsp_b", rsp_b, 16'h4444);
        step();
        chk("fl_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
